// File: rtl/spread_frame_sched.sv
// -----------------------------------------------------------------------------
// spread_frame_sched
//   Frame scheduler in front of the spectrum spreader. Round-robin arbitrates
//   between N_REQ byte-stream requesters and grants one for a whole frame. The
//   frame is then serialised MSB-first, one bit at a time, over a valid/ready
//   link. A frame is a fixed preamble followed by the granted requester's
//   payload bytes. After each frame the link idles for GAP_CYC cycles.
//
//   Optional build macro: SPREAD_SCHED_PARITY_EN
//     When it is defined, one even-parity bit follows the last payload bit.
//     This bit is the XOR of all payload bits; the preamble is not included.
//
// Ports
//   i_clk, i_reset      clock and synchronous active-high reset
//   i_req[N]            per-requester frame request (level)
//   i_byte[8N]          payload bytes, requester k on [8k+7:8k]
//   i_byte_valid[N]     byte valid per requester
//   i_last[N]           last payload byte of the frame (qualified by valid)
//   o_byte_ready[N]     one-hot byte ready, only for the granted requester
//   o_grant[N]          one-hot grant, held for the whole frame
//   o_sp_data           serial bit to the spreader
//   o_sp_valid          serial bit valid, held until consumed
//   i_sp_ready          spreader ready
//   o_sp_enable         spreader enable
//   o_busy              high in every state except IDLE
//   o_frame_done        1-cycle pulse after the final frame bit is consumed
// -----------------------------------------------------------------------------
module spread_frame_sched #(
    parameter int          N_REQ    = 4,
    parameter logic [15:0] PREAMBLE = 16'hF5A0,
    parameter int          PRE_LEN  = 16,
    parameter int          GAP_CYC  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_byte,
    input  logic [N_REQ-1:0]   i_byte_valid,
    input  logic [N_REQ-1:0]   i_last,
    output logic [N_REQ-1:0]   o_byte_ready,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_sp_data,
    output logic               o_sp_valid,
    input  logic               i_sp_ready,
    output logic               o_sp_enable,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_PRE  = 3'd2,
        ST_LOAD = 3'd3,
        ST_PAY  = 3'd4,
        ST_GAP  = 3'd5
`ifdef SPREAD_SCHED_PARITY_EN
        , ST_PAR = 3'd6
`endif
    } state_t;

`ifdef SPREAD_SCHED_PARITY_EN
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   byte_ready_q;
    logic               sp_data_q;
    logic               sp_valid_q;
    logic               enable_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         pre_cnt_q;
    logic [2:0]         pay_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [7:0]         byte_q;
    logic               last_q;
`ifdef SPREAD_SCHED_PARITY_EN
    logic               par_q;
`endif

    logic [N_REQ-1:0]   arb_grant_d;
    logic [PTR_W-1:0]   arb_idx_d;
    logic               arb_found_d;
    logic [PTR_W-1:0]   ptr_next_d;
    logic [7:0]         sel_byte_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic               consume_s;

    assign consume_s = sp_valid_q & i_sp_ready;

    // Round-robin search: first requesting index at or after ptr_q, wrapping.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        arb_grant_d = '0;
        arb_idx_d   = '0;
        arb_found_d = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end else begin
                sum = sum;
            end
            idx = sum[PTR_W-1:0];
            if (!arb_found_d && i_req[idx]) begin
                arb_found_d      = 1'b1;
                arb_grant_d[idx] = 1'b1;
                arb_idx_d        = idx;
            end else begin
                arb_found_d = arb_found_d;
            end
        end
    end

    // Pointer moves to the requester just after the winner.
    always_comb begin
        if (arb_idx_d == PTR_W'(N_REQ - 1)) begin
            ptr_next_d = '0;
        end else begin
            ptr_next_d = arb_idx_d + PTR_W'(1);
        end
    end

    // One-hot mux of the granted requester's byte lane; other lanes are masked out.
    always_comb begin
        sel_byte_s  = 8'h00;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sel_byte_s  = sel_byte_s | (i_byte[8*k +: 8] & {8{grant_q[k]}});
            sel_valid_s = sel_valid_s | (i_byte_valid[k] & grant_q[k]);
            sel_last_s  = sel_last_s | (i_last[k] & grant_q[k]);
        end
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            byte_ready_q <= '0;
            sp_data_q    <= 1'b0;
            sp_valid_q   <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pre_cnt_q    <= 4'd0;
            pay_cnt_q    <= 3'd0;
            gap_cnt_q    <= '0;
            byte_q       <= 8'h00;
            last_q       <= 1'b0;
`ifdef SPREAD_SCHED_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|i_req) begin
                        state_q <= ST_ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    // A request that vanished before arbitration returns to IDLE.
                    if (arb_found_d) begin
                        grant_q    <= arb_grant_d;
                        ptr_q      <= ptr_next_d;
                        enable_q   <= 1'b1;
                        sp_valid_q <= 1'b1;
                        sp_data_q  <= PREAMBLE[PRE_LEN-1];
                        pre_cnt_q  <= 4'(PRE_LEN - 1);
`ifdef SPREAD_SCHED_PARITY_EN
                        par_q      <= 1'b0;
`endif
                        state_q    <= ST_PRE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRE: begin
                    if (consume_s) begin
                        if (pre_cnt_q == 4'd0) begin
                            sp_valid_q   <= 1'b0;
                            byte_ready_q <= grant_q;
                            state_q      <= ST_LOAD;
                        end else begin
                            pre_cnt_q <= pre_cnt_q - 4'd1;
                            sp_data_q <= PREAMBLE[pre_cnt_q - 4'd1];
                        end
                    end
                end
                ST_LOAD: begin
                    // Ready is high for the whole of LOAD, so valid alone accepts.
                    if (sel_valid_s) begin
                        byte_q       <= sel_byte_s;
                        last_q       <= sel_last_s;
                        byte_ready_q <= '0;
                        sp_valid_q   <= 1'b1;
                        sp_data_q    <= sel_byte_s[7];
                        pay_cnt_q    <= 3'd7;
`ifdef SPREAD_SCHED_PARITY_EN
                        par_q        <= par_q ^ byte_parity(sel_byte_s);
`endif
                        state_q      <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (consume_s) begin
                        if (pay_cnt_q == 3'd0) begin
                            if (last_q) begin
`ifdef SPREAD_SCHED_PARITY_EN
                                sp_data_q <= par_q;
                                state_q   <= ST_PAR;
`else
                                sp_valid_q <= 1'b0;
                                done_q     <= 1'b1;
                                gap_cnt_q  <= '0;
                                state_q    <= ST_GAP;
`endif
                            end else begin
                                sp_valid_q   <= 1'b0;
                                byte_ready_q <= grant_q;
                                state_q      <= ST_LOAD;
                            end
                        end else begin
                            pay_cnt_q <= pay_cnt_q - 3'd1;
                            sp_data_q <= byte_q[pay_cnt_q - 3'd1];
                        end
                    end
                end
`ifdef SPREAD_SCHED_PARITY_EN
                ST_PAR: begin
                    if (consume_s) begin
                        sp_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        gap_cnt_q  <= '0;
                        state_q    <= ST_GAP;
                    end
                end
`endif
                ST_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                        grant_q  <= '0;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    grant_q      <= '0;
                    byte_ready_q <= '0;
                    sp_valid_q   <= 1'b0;
                    enable_q     <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready = byte_ready_q;
    assign o_grant      = grant_q;
    assign o_sp_data    = sp_data_q;
    assign o_sp_valid   = sp_valid_q;
    assign o_sp_enable  = enable_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_spread_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_spread_frame_sched
//   Scoreboard bench for spread_frame_sched. Expected serial bits are queued
//   as each frame's payload is prepared; the bits the spreader consumes are
//   queued by the frame driver. Each test task then pops both queues and
//   compares them, together with grant, timing and link-rule observations.
// -----------------------------------------------------------------------------
module tb_spread_frame_sched;

    localparam int N = 4;
`ifdef SPREAD_SCHED_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, byte_valid, last, byte_ready, grant;
    logic [8*N-1:0] byte_bus;
    logic           sp_data, sp_valid, sp_ready, sp_enable, busy, frame_done;

    always #5 clk = ~clk;

    spread_frame_sched dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req        (req),
        .i_byte       (byte_bus),
        .i_byte_valid (byte_valid),
        .i_last       (last),
        .o_byte_ready (byte_ready),
        .o_grant      (grant),
        .o_sp_data    (sp_data),
        .o_sp_valid   (sp_valid),
        .i_sp_ready   (sp_ready),
        .o_sp_enable  (sp_enable),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;

    bit         exp_q[$];
    bit         rx_q[$];
    logic [7:0] pay_q[$];
    bit         exp_par;

    logic [N-1:0] first_grant;
    int  done_cnt, done_cyc, last_cons_cyc;
    int  stab_bad, stall_bad, rdy_bad, en_bad;
    bit  timed_out, prev_hold, prev_data;

    task automatic push_pre();
        logic [15:0] p;
        p = 16'hF5A0;
        for (int i = 15; i >= 0; i--) exp_q.push_back(p[i]);
        exp_par = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        pay_q.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(b[i]);
            exp_par = exp_par ^ b[i];
        end
    endtask

    task automatic push_end();
        if (PAR_EN) exp_q.push_back(exp_par);
    endtask

    // Drives one frame: byte source for the granted requester, noise on the
    // others, spreader ready; records consumed bits and link observations.
    task automatic run_frame(input int budget, input bit rnd, input int stall, input bit drop_req);
        int stall_left;
        int src;
        bit fin;
        bit acc;
        stall_left = 0; src = -1; fin = 1'b0;
        first_grant = '0; done_cnt = 0; done_cyc = -1; last_cons_cyc = -5;
        stab_bad = 0; stall_bad = 0; rdy_bad = 0; en_bad = 0;
        timed_out = 1'b0; prev_hold = 1'b0; prev_data = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            if (sp_valid && sp_ready) begin
                rx_q.push_back(sp_data);
                last_cons_cyc = c;
            end
            if (prev_hold && (!sp_valid || sp_data !== prev_data)) stab_bad++;
            prev_hold = sp_valid && !sp_ready;
            prev_data = sp_data;
            if (frame_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (sp_valid && !sp_enable) en_bad++;
            if (|byte_ready && sp_valid) stall_bad++;
            if (first_grant == '0 && grant != '0) begin
                first_grant = grant;
                for (int k = 0; k < N; k++) if (grant[k]) src = k;
            end
            if ((byte_ready & ~grant) != '0) rdy_bad++;
            acc = (src >= 0) && byte_valid[src] && byte_ready[src];
            if (done_cnt > 0 && !busy) fin = 1'b1;
            @(posedge clk);
            #1;
            sp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drop_req && src >= 0) req = '0;
            if (acc) begin
                void'(pay_q.pop_front());
                stall_left = stall;
            end else if (stall_left > 0) begin
                stall_left--;
            end
            for (int k = 0; k < N; k++) begin
                if (k == src) begin
                    if (pay_q.size() > 0 && stall_left == 0) begin
                        byte_valid[k]       = 1'b1;
                        byte_bus[8*k +: 8]  = pay_q[0];
                        last[k]             = (pay_q.size() == 1);
                    end else begin
                        byte_valid[k]       = 1'b0;
                        byte_bus[8*k +: 8]  = 8'h00;
                        last[k]             = 1'b0;
                    end
                end else begin
                    byte_valid[k]      = 1'b1;
                    byte_bus[8*k +: 8] = 8'hFF;
                    last[k]            = 1'b1;
                end
            end
        end
        if (!fin) timed_out = 1'b1;
        byte_valid = '0;
        last       = '0;
        pay_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({grant, byte_ready, sp_data, sp_valid, sp_enable, busy, frame_done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got grant=%b rdy=%b d=%b v=%b en=%b busy=%b done=%b exp all zero",
                         i, grant, byte_ready, sp_data, sp_valid, sp_enable, busy, frame_done);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        bit br, be;
        int exp_len;
        req = 4'b0010;
        push_pre();
        push_byte(8'hC3);
        push_end();
        exp_len = exp_q.size();
        run_frame(600, 1'b0, 0, 1'b1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL t2_timeout got=1 exp=0"); end
        checks++;
        if (first_grant !== 4'b0010) begin errors++; $display("FAIL t2_grant got=%b exp=0010", first_grant); end
        checks++;
        if (rx_q.size() !== 24 + int'(PAR_EN)) begin
            errors++; $display("FAIL t2_len got=%0d exp=%0d", rx_q.size(), exp_len);
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL t2_done_count got=%0d exp=1", done_cnt); end
        checks++;
        if (done_cyc !== last_cons_cyc + 1) begin
            errors++; $display("FAIL t2_done_timing got=%0d exp=%0d", done_cyc, last_cons_cyc + 1);
        end
        checks++;
        if (en_bad !== 0 || rdy_bad !== 0) begin
            errors++; $display("FAIL t2_enable_ready got en_bad=%0d rdy_bad=%0d exp 0 0", en_bad, rdy_bad);
        end
        for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
            br = rx_q.pop_front(); be = exp_q.pop_front();
            checks++;
            if (br !== be) begin errors++; $display("FAIL t2_bit%0d got=%b exp=%b", i, br, be); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_pay();
        int cnt;
        cnt = 0;
        req        = 4'b0100;
        sp_ready   = 1'b1;
        byte_valid = '1;
        last       = '0;
        byte_bus   = {4{8'hAA}};
        for (int c = 0; c < 400 && cnt < 20; c++) begin
            @(negedge clk);
            if (sp_valid && sp_ready) cnt++;
        end
        checks++;
        if (cnt < 20) begin errors++; $display("FAIL t1_reach_pay got=%0d exp=20", cnt); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({grant, byte_ready, sp_data, sp_valid, sp_enable, busy, frame_done} !== '0) begin
                errors++;
                $display("FAIL t1_mid_reset cycle=%0d got grant=%b rdy=%b d=%b v=%b en=%b busy=%b done=%b exp all zero",
                         i, grant, byte_ready, sp_data, sp_valid, sp_enable, busy, frame_done);
            end
        end
        reset      = 1'b0;
        req        = '0;
        byte_valid = '0;
        byte_bus   = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5];
        bit br, be;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_pre();
            push_byte(8'(16 + k));
            push_end();
            run_frame(800, 1'b0, 0, k == 4);
            checks++;
            if (timed_out) begin errors++; $display("FAIL t3_timeout frame=%0d", k); end
            checks++;
            if (first_grant !== exp_g[k]) begin
                errors++; $display("FAIL t3_grant frame=%0d got=%b exp=%b", k, first_grant, exp_g[k]);
            end
            checks++;
            if (rx_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL t3_len frame=%0d got=%0d exp=%0d", k, rx_q.size(), exp_q.size());
            end
            for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
                br = rx_q.pop_front(); be = exp_q.pop_front();
                checks++;
                if (br !== be) begin errors++; $display("FAIL t3_bit f%0d b%0d got=%b exp=%b", k, i, br, be); end
            end
            rx_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        bit br, be;
        req = 4'b1000;
        push_pre();
        push_byte(8'($urandom_range(0, 255)));
        push_byte(8'($urandom_range(0, 255)));
        push_end();
        run_frame(3000, 1'b1, 0, 1'b1);
        sp_ready = 1'b1;
        checks++;
        if (timed_out) begin errors++; $display("FAIL t4_timeout got=1 exp=0"); end
        checks++;
        if (first_grant !== 4'b1000) begin errors++; $display("FAIL t4_grant got=%b exp=1000", first_grant); end
        checks++;
        if (stab_bad !== 0) begin errors++; $display("FAIL t4_link_stable got=%0d exp=0", stab_bad); end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_cons_cyc + 1) begin
            errors++; $display("FAIL t4_done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", done_cnt, done_cyc, last_cons_cyc + 1);
        end
        checks++;
        if (rx_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL t4_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
            br = rx_q.pop_front(); be = exp_q.pop_front();
            checks++;
            if (br !== be) begin errors++; $display("FAIL t4_bit%0d got=%b exp=%b", i, br, be); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_multibyte_stall();
        bit br, be;
        req = 4'b0001;
        push_pre();
        push_byte(8'h01);
        push_byte(8'h80);
        push_end();
        run_frame(1000, 1'b0, 10, 1'b1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL t5_timeout got=1 exp=0"); end
        checks++;
        if (first_grant !== 4'b0001) begin errors++; $display("FAIL t5_grant got=%b exp=0001", first_grant); end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL t5_valid_in_load got=%0d exp=0", stall_bad); end
        checks++;
        if (rdy_bad !== 0) begin errors++; $display("FAIL t5_ready_onehot got=%0d exp=0", rdy_bad); end
        checks++;
        if (rx_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL t5_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
            br = rx_q.pop_front(); be = exp_q.pop_front();
            checks++;
            if (br !== be) begin errors++; $display("FAIL t5_bit%0d got=%b exp=%b", i, br, be); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_parity();
        logic [7:0] pb [2];
        bit br, be;
        pb = '{8'h07, 8'h03};
        for (int k = 0; k < 2; k++) begin
            req = 4'b0100;
            push_pre();
            push_byte(pb[k]);
            push_end();
            run_frame(800, 1'b0, 0, 1'b1);
            checks++;
            if (timed_out) begin errors++; $display("FAIL t6_timeout frame=%0d", k); end
            checks++;
            if (rx_q.size() !== 24 + int'(PAR_EN)) begin
                errors++; $display("FAIL t6_len frame=%0d got=%0d exp=%0d", k, rx_q.size(), 24 + int'(PAR_EN));
            end
            for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
                br = rx_q.pop_front(); be = exp_q.pop_front();
                checks++;
                if (br !== be) begin errors++; $display("FAIL t6_bit f%0d b%0d got=%b exp=%b", k, i, br, be); end
            end
            rx_q.delete(); exp_q.delete();
        end
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        byte_valid = '0;
        last       = '0;
        byte_bus   = '0;
        sp_ready   = 1'b1;
        test_reset();
        test_single_frame();
        test_reset_mid_pay();
        test_round_robin();
        test_backpressure();
        test_multibyte_stall();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
